// File: rtl/axis_frame_gen_pkg.sv
// Shared AXIS types, Ethernet header constants and the frame byte generator
// used by the frame generator.
package axis_frame_gen_pkg;

  localparam int unsigned ETH_HDR_BYTES = 14;
  localparam int unsigned MIN_LEN_DEF   = 60;
  localparam int unsigned MAX_LEN_DEF   = 1514;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [0:0]  user;
  } s_beat_t;

  typedef struct packed {
    s_beat_t t;
    logic    tvalid;
  } s_req_t;

  typedef struct packed {
    logic tready;
  } s_rsp_t;

  // hdr holds {dst, src, ethertype}; byte 0 on the wire is hdr[111:104].
  function automatic logic [7:0] eth_gen_byte(input logic [111:0] hdr,
                                              input logic [7:0]   idx,
                                              input logic [10:0]  n);
    logic [7:0] b;
    logic [3:0] hb;
    hb = 4'd0;
    if (n < 11'(ETH_HDR_BYTES)) begin
      hb = 4'd13 - n[3:0];
      b  = hdr[{hb, 3'b000} +: 8];
    end else begin
      b = idx + 8'(n - 11'(ETH_HDR_BYTES));
    end
    return b;
  endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// Ethernet frame generator: AXI-Stream master emitting bursts of header +
// incrementing-payload frames with a programmable inter-frame gap.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter type         axi_stream_req_t = s_req_t,
  parameter type         axi_stream_rsp_t = s_rsp_t,
  parameter int unsigned DataWidth        = 64,
  parameter int unsigned UserWidth        = 1,
  parameter int unsigned MinLen           = MIN_LEN_DEF,
  parameter int unsigned MaxLen           = MAX_LEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic [47:0]     dst_mac_i,
  input  logic [47:0]     src_mac_i,
  input  logic [15:0]     ethertype_i,
  input  logic [15:0]     len_i,
  input  logic [15:0]     num_frames_i,
  input  logic [7:0]      gap_i,
  output axi_stream_req_t tx_axis_req_o,
  input  axi_stream_rsp_t tx_axis_rsp_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [31:0]     frames_sent_o
);

  if (DataWidth != 64 || UserWidth != 1) begin : g_param_check
    $error("axis_frame_gen: only DataWidth=64 and UserWidth=1 are supported");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [111:0] hdr_q, hdr_d;
  logic [10:0]  len_q, len_d;
  logic [7:0]   last_beat_q, last_beat_d;
  logic [15:0]  num_q, num_d;
  logic [7:0]   gap_cfg_q, gap_cfg_d;
  logic [7:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]   beat_q, beat_d;
  logic [15:0]  frame_idx_q, frame_idx_d;
  logic         stop_q, stop_d;
  logic         done_q, done_d;
  logic [31:0]  sent_q, sent_d;

  logic        valid, hs, is_last, stop_seen, burst_end;
  logic [15:0] frame_next;
  logic [10:0] len_clamped;
  logic [7:0]  keep;
  logic [63:0] data;

  always_comb begin
    if (len_i < 16'(MinLen))      len_clamped = 11'(MinLen);
    else if (len_i > 16'(MaxLen)) len_clamped = 11'(MaxLen);
    else                          len_clamped = len_i[10:0];
  end

  assign valid      = (state_q == SEND);
  assign is_last    = (beat_q == last_beat_q);
  assign hs         = valid && tx_axis_rsp_i.tready;
  assign stop_seen  = stop_q || stop_i;
  assign frame_next = frame_idx_q + 16'd1;
  assign burst_end  = ((num_q != 16'd0) && (frame_next == num_q)) || stop_seen;

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    len_d       = len_q;
    last_beat_d = last_beat_q;
    num_d       = num_q;
    gap_cfg_d   = gap_cfg_q;
    gap_cnt_d   = gap_cnt_q;
    beat_d      = beat_q;
    frame_idx_d = frame_idx_q;
    stop_d      = stop_q;
    sent_d      = sent_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          hdr_d       = {dst_mac_i, src_mac_i, ethertype_i};
          len_d       = len_clamped;
          // (L-1)/8 is the index of the final beat, i.e. ceil(L/8)-1
          last_beat_d = 8'((len_clamped - 11'd1) >> 3);
          num_d       = num_frames_i;
          gap_cfg_d   = gap_i;
          beat_d      = 8'd0;
          frame_idx_d = 16'd0;
          stop_d      = stop_i;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (stop_i) stop_d = 1'b1;
        if (hs) begin
          beat_d = beat_q + 8'd1;
          if (is_last) begin
            beat_d      = 8'd0;
            frame_idx_d = frame_next;
            sent_d      = sent_q + 32'd1;
            if (burst_end) begin
              state_d = IDLE;
              done_d  = 1'b1;
              stop_d  = 1'b0;
            end else if (gap_cfg_q != 8'd0) begin
              state_d   = GAP;
              gap_cnt_d = gap_cfg_q - 8'd1;
            end
          end
        end
      end
      GAP: begin
        if (stop_i) stop_d = 1'b1;
        if (gap_cnt_q == 8'd0) begin
          if (stop_seen) begin
            state_d = IDLE;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else begin
            state_d = SEND;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      len_q       <= '0;
      last_beat_q <= '0;
      num_q       <= '0;
      gap_cfg_q   <= '0;
      gap_cnt_q   <= '0;
      beat_q      <= '0;
      frame_idx_q <= '0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      sent_q      <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      len_q       <= len_d;
      last_beat_q <= last_beat_d;
      num_q       <= num_d;
      gap_cfg_q   <= gap_cfg_d;
      gap_cnt_q   <= gap_cnt_d;
      beat_q      <= beat_d;
      frame_idx_q <= frame_idx_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      sent_q      <= sent_d;
    end
  end

  // Beat content depends only on registered state, so it is stable while stalled.
  always_comb begin
    logic [10:0] n;
    keep = 8'h00;
    data = 64'h0;
    for (int lane = 0; lane < 8; lane++) begin
      n = {beat_q, 3'b000} | 11'(lane);
      keep[lane] = !is_last || (len_q[2:0] == 3'd0) || (3'(lane) < len_q[2:0]);
      if (keep[lane]) data[8*lane +: 8] = eth_gen_byte(hdr_q, frame_idx_q[7:0], n);
    end
  end

  always_comb begin
    tx_axis_req_o = '0;
    if (valid) begin
      tx_axis_req_o.tvalid = 1'b1;
      tx_axis_req_o.t.data = data;
      tx_axis_req_o.t.keep = keep;
      tx_axis_req_o.t.strb = keep;
      tx_axis_req_o.t.last = is_last;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign frames_sent_o = sent_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Randomized bench for axis_frame_gen with a byte-level frame model and
// per-cycle comparison of the AXIS stream, status outputs and gaps.
module tb_axis_frame_gen;
  import axis_frame_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i, stop_i;
  logic [47:0] dst_mac_i, src_mac_i;
  logic [15:0] ethertype_i, len_i, num_frames_i;
  logic [7:0]  gap_i;
  s_req_t      tx_req;
  s_rsp_t      tx_rsp;
  logic        tready;
  logic        busy_o, done_o;
  logic [31:0] frames_sent_o;

  always #5 clk = ~clk;
  assign tx_rsp.tready = tready;

  axis_frame_gen dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .dst_mac_i(dst_mac_i), .src_mac_i(src_mac_i), .ethertype_i(ethertype_i),
    .len_i(len_i), .num_frames_i(num_frames_i), .gap_i(gap_i),
    .tx_axis_req_o(tx_req), .tx_axis_rsp_i(tx_rsp),
    .busy_o(busy_o), .done_o(done_o), .frames_sent_o(frames_sent_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_len, m_num, m_gap, m_beat, m_idle;
  logic [47:0] m_dst, m_src;
  logic [15:0] m_type, m_frame;
  logic [31:0] m_sent;
  logic        m_busy, m_stop, m_done_exp, m_in_gap;
  logic        ready_rnd;
  int          done_cnt, d_beats, d_tlast_cnt, cap_beats;
  logic [7:0]  cap_keep;
  logic [63:0] cap_beat0;
  logic [7:0]  cap_b14 [8];
  logic        prev_valid, prev_ready;
  logic [63:0] prev_data;
  logic [16:0] prev_ctl;

  function automatic logic [7:0] exp_byte(input logic [15:0] k, input int n);
    logic [7:0] b;
    if (n < 6)       b = 8'(m_dst >> (8 * (5 - n)));
    else if (n < 12) b = 8'(m_src >> (8 * (11 - n)));
    else if (n < 14) b = 8'(m_type >> (8 * (13 - n)));
    else             b = 8'((int'(k[7:0]) + n - 14) % 256);
    return b;
  endfunction

  always @(negedge clk) begin
    logic        was_busy, exp_last;
    logic [63:0] exp_data;
    logic [7:0]  exp_keep;
    if (!rst_ni) begin
      m_busy = 0; m_sent = 0; m_done_exp = 0; m_in_gap = 0; m_stop = 0;
      m_beat = 0; m_frame = 0; prev_valid = 0; prev_ready = 0; d_beats = 0;
    end else begin
      was_busy = m_busy;
      check("frames_sent", 64'(frames_sent_o), 64'(m_sent));
      check("done", 64'(done_o), 64'(m_done_exp));
      check("busy", 64'(busy_o), 64'(m_busy));
      if (done_o) done_cnt++;
      m_done_exp = 0;
      if (prev_valid && !prev_ready) begin
        check("stall_valid", 64'(tx_req.tvalid), 64'd1);
        check("stall_data", tx_req.t.data, prev_data);
        check("stall_ctl", 64'({tx_req.t.keep, tx_req.t.strb, tx_req.t.last}), 64'(prev_ctl));
      end
      if (tx_req.tvalid) check("id_dest_user", 64'({tx_req.t.id, tx_req.t.dest, tx_req.t.user}), 64'd0);
      if (m_in_gap) begin
        if (tx_req.tvalid) begin
          check("gap_len", 64'(m_idle), 64'(m_gap));
          m_in_gap = 0;
        end else begin
          m_idle++;
          if (m_idle == m_gap && (m_stop || stop_i)) begin
            m_busy = 0; m_done_exp = 1; m_in_gap = 0; m_stop = 0;
          end
        end
      end else begin
        check("tvalid", 64'(tx_req.tvalid), 64'(m_busy));
      end
      if (tx_req.tvalid && tready && m_busy && !m_in_gap) begin
        exp_data = 64'h0; exp_keep = 8'h00;
        for (int l = 0; l < 8; l++) begin
          if (8 * m_beat + l < m_len) begin
            exp_data[8*l +: 8] = exp_byte(m_frame, 8 * m_beat + l);
            exp_keep[l] = 1'b1;
          end
        end
        exp_last = (8 * (m_beat + 1) >= m_len);
        check("beat_data", tx_req.t.data, exp_data);
        check("beat_keep", 64'(tx_req.t.keep), 64'(exp_keep));
        check("beat_strb", 64'(tx_req.t.strb), 64'(exp_keep));
        check("beat_last", 64'(tx_req.t.last), 64'(exp_last));
        if (m_beat == 0 && m_frame == 0) cap_beat0 = tx_req.t.data;
        if (m_beat == 1 && m_frame < 8) cap_b14[m_frame[2:0]] = tx_req.t.data[55:48];
        d_beats++;
        if (tx_req.t.last) begin
          cap_beats = d_beats; cap_keep = tx_req.t.keep; d_beats = 0; d_tlast_cnt++;
        end
        m_beat++;
        if (exp_last) begin
          m_beat = 0; m_frame++; m_sent++;
          if ((m_num != 0 && int'(m_frame) == m_num) || m_stop || stop_i) begin
            m_busy = 0; m_done_exp = 1; m_stop = 0;
          end else if (m_gap > 0) begin
            m_in_gap = 1; m_idle = 0;
          end
        end
      end
      if (m_busy && stop_i) m_stop = 1;
      if (!was_busy && start_i) begin
        m_len  = (len_i < 60) ? 60 : (len_i > 1514) ? 1514 : int'(len_i);
        m_num  = int'(num_frames_i); m_gap = int'(gap_i);
        m_dst  = dst_mac_i; m_src = src_mac_i; m_type = ethertype_i;
        m_busy = 1; m_frame = 0; m_beat = 0; m_stop = stop_i; m_in_gap = 0; d_beats = 0;
      end
      prev_valid = tx_req.tvalid; prev_ready = tready;
      prev_data  = tx_req.t.data;
      prev_ctl   = {tx_req.t.keep, tx_req.t.strb, tx_req.t.last};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 tready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    bit seen;
    c0 = done_cnt; seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != c0) begin seen = 1; break; end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic burst(input int len, input int num, input int gap, input logic rnd, input int budget);
    len_i = 16'(len); num_frames_i = 16'(num); gap_i = 8'(gap); ready_rnd = rnd;
    pulse_start();
    wait_done(budget);
    @(posedge clk); #1;
  endtask

  task automatic wait_model(input int frame, input int beat, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (int'(m_frame) == frame && m_beat == beat) begin hit = 1; break; end
    end
    check("reach_point", 64'(hit), 64'd1);
  endtask

  initial begin
    int t0;
    rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; ready_rnd = 1'b0; tready = 1'b1;
    dst_mac_i = 48'h02_00_00_00_00_01; src_mac_i = 48'h02_00_00_00_00_02;
    ethertype_i = 16'h0800; len_i = 16'd60; num_frames_i = 16'd1; gap_i = 8'd0;
    done_cnt = 0; d_tlast_cnt = 0; cap_beats = 0; cap_keep = 0; cap_beat0 = 0;
    #12;
    check("rst_tvalid", 64'(tx_req.tvalid), 64'd0);
    check("rst_tdata", tx_req.t.data, 64'd0);
    check("rst_ctl", 64'({tx_req.t.keep, tx_req.t.strb, tx_req.t.last}), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_frames", 64'(frames_sent_o), 64'd0);
    @(posedge clk); #1 rst_ni = 1'b1;

    // 1: single minimum frame
    burst(60, 1, 0, 1'b0, 200);
    check("t1_beat0", cap_beat0, 64'h0002_0100_0000_0002);
    check("t1_beats", 64'(cap_beats), 64'd8);
    check("t1_keep", 64'(cap_keep), 64'h0F);
    check("t1_frames", 64'(frames_sent_o), 64'd1);

    // 2: three frames with a 4-cycle gap
    burst(61, 3, 4, 1'b0, 400);
    check("t2_keep", 64'(cap_keep), 64'h1F);
    check("t2_payload0", 64'(cap_b14[2]), 64'h02);
    check("t2_frames", 64'(frames_sent_o), 64'd4);

    // 3: random header and gap, random backpressure
    dst_mac_i = {$urandom, $urandom} >> 16; src_mac_i = {$urandom, $urandom} >> 16;
    ethertype_i = 16'($urandom);
    burst(64, 2, int'($urandom_range(0, 3)), 1'b1, 1000);
    check("t3_keep", 64'(cap_keep), 64'hFF);
    check("t3_frames", 64'(frames_sent_o), 64'd6);

    // 4: length clamping at both ends
    burst(10, 1, 0, 1'b0, 200);
    check("t4_min_beats", 64'(cap_beats), 64'd8);
    burst(2000, 1, 0, 1'b0, 1000);
    check("t4_max_beats", 64'(cap_beats), 64'd190);
    check("t4_max_keep", 64'(cap_keep), 64'h03);

    // 5: continuous mode, ignored restart, stop in frame 5
    len_i = 16'd60; num_frames_i = 16'd0; gap_i = 8'd0; ready_rnd = 1'b0;
    t0 = d_tlast_cnt;
    pulse_start();
    wait_model(2, 0, 200);
    len_i = 16'd200; num_frames_i = 16'd1; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_model(5, 3, 200);
    stop_i = 1'b1;
    @(posedge clk); #1 stop_i = 1'b0;
    wait_done(200);
    @(posedge clk); #1;
    check("t5_frames_in_burst", 64'(d_tlast_cnt - t0), 64'd6);
    check("t5_frames", 64'(frames_sent_o), 64'd14);

    // 6: reset mid-frame, then a clean frame 0
    dst_mac_i = 48'h02_00_00_00_00_01; src_mac_i = 48'h02_00_00_00_00_02;
    ethertype_i = 16'h0800;
    len_i = 16'd100; num_frames_i = 16'd2; gap_i = 8'd2;
    pulse_start();
    wait_model(0, 5, 200);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_tvalid", 64'(tx_req.tvalid), 64'd0);
    check("t6_frames", 64'(frames_sent_o), 64'd0);
    check("t6_busy", 64'(busy_o), 64'd0);
    check("t6_done", 64'(done_o), 64'd0);
    cap_beat0 = 64'h0;
    @(posedge clk); @(posedge clk); #1 rst_ni = 1'b1;
    burst(60, 1, 0, 1'b0, 200);
    check("t6_beat0", cap_beat0, 64'h0002_0100_0000_0002);
    check("t6_frames_after", 64'(frames_sent_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
